rpn_stack_controller: RTL and testbench
=======================================

Name: rpn_stack_controller

Overview:
Sequencer that puts a DEPTH-entry operand stack in front of the shared ALU input/output-register datapath, giving a true RPN calculator. Operand Enters push DataIn. An opcode Enter pops two operands, drives the ALU load strobes in a fixed cycle sequence, and pushes the result. Undo pops the top entry, or restores the operands of the last operation. It sits between the Level_to_pulse stages and the ALU, replacing the flat ReversePolishFSM sequencing.

Parameters:
N, 16, data/operand width (matches ALU N)
DEPTH, 4, stack entries (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
enter_pulse  in  1  one-cycle Enter pulse
undo_pulse  in  1  one-cycle Undo pulse
is_op  in  1  1: DataIn holds an opcode; 0: DataIn holds an operand
data_in  in  N  switch data
alu_result  in  N  registered ALU Result
alu_data  out  N  data bus to ALU data_in
load_A  out  1  ALU load_A strobe
load_B  out  1  ALU load_B strobe
load_Op  out  1  ALU load_Op strobe
update_res  out  1  ALU updateRes strobe
top_value  out  N  stack top; 0 when empty
depth  out  $clog2(DEPTH+1)  current entry count
busy  out  1  operation sequence in progress
stack_err  out  1  sticky error flag

Behaviour:
- One clock (clk); reset synchronous active-high. On reset: depth=0, all entries=0, state IDLE, strobes=0, busy=0, stack_err=0, history invalid, alu_data=0.
- States: IDLE, LD_A, LD_B, LD_OP, EXEC, WB.
- All commands are accepted only in IDLE. Enter/undo while busy are ignored (no state change, no error).
- If undo_pulse and enter_pulse are high together in IDLE, undo wins and enter is dropped.
- Push (enter, is_op=0):
  - If depth<DEPTH: entry[depth]=data_in, depth+1. New value appears on top_value the next cycle.
  - If depth==DEPTH: no change, stack_err=1.
- Operation (enter, is_op=1):
  - If depth<2: no strobes, stack_err=1, stay IDLE.
  - Else latch opcode=data_in and go to LD_A. busy=1 from LD_A through WB.
- Sequence, one cycle per state, each strobe high exactly one cycle:
  - LD_A: alu_data=entry[depth-2] (second from top), load_A=1.
  - LD_B: alu_data=entry[depth-1] (top), load_B=1.
  - LD_OP: alu_data=latched opcode, load_Op=1.
  - EXEC: update_res=1.
  - WB: alu_result is valid. Save the A/B operands to history (hist_valid=1). entry[depth-2]=alu_result, depth-1. Return to IDLE.
- Command-to-writeback latency: 5 cycles. The new top_value is visible the cycle after WB.
- In all non-strobe cycles, alu_data holds 0 and all strobes are 0.
- Undo (IDLE):
  - If hist_valid: replace the top with the saved A then B (top=B), depth+1, hist_valid=0.
  - Else if depth>0: depth-1. The popped entry is cleared to 0.
  - Else: stack_err=1.
- hist_valid is cleared by any accepted push or pop.
- A rejected command (overflow or underflow) leaves hist_valid unchanged.
- stack_err is sticky. It is cleared by the next accepted command (push, operation start, or undo) or by reset.
- Reset mid-sequence returns to IDLE in the reset cycle. No further strobes are issued.
- Width: all entries N bits. The ALU result is taken as-is (no extension or truncation). Stack indices never wrap.

Test Plan:
- Push 0x0003, push 0x0005, op enter with data_in=0x0000 -> load_A with alu_data=0x0003, then load_B with 0x0005, then load_Op with 0x0000, then update_res, on consecutive cycles; WB pushes alu_result (model 0x0008); depth 2->1; top_value=0x0008.
- Push 0x0001..0x0004, then push 0x0009 -> depth stays 4, top_value=0x0004, stack_err=1; next undo -> depth 3, top_value=0x0003, stack_err=0.
- Empty stack, push 0x0007, op enter -> no strobes ever asserted, stack_err=1, depth=1; undo on this stack -> depth 0, then undo again -> stack_err=1.
- After the first test's operation, undo -> depth 2, top_value=0x0005, entry below=0x0003; second undo -> plain pop, depth 1, top_value=0x0003.
- Enter and undo pulses issued during LD_B -> ignored; sequence completes unchanged in 5 cycles. Simultaneous enter+undo in IDLE with depth 2 -> pop only, no push.
- Reset asserted during LD_OP -> next cycle all outputs 0, depth 0, no update_res pulse afterwards.

Source files
------------

// File: rtl/rpn_stack_controller.sv
// RPN stack sequencer: DEPTH-entry operand stack feeding the shared ALU load strobes.
module rpn_stack_controller #(
  parameter int unsigned N     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enter_pulse,
  input  logic                       undo_pulse,
  input  logic                       is_op,
  input  logic [N-1:0]               data_in,
  input  logic [N-1:0]               alu_result,
  output logic [N-1:0]               alu_data,
  output logic                       load_A,
  output logic                       load_B,
  output logic                       load_Op,
  output logic                       update_res,
  output logic [N-1:0]               top_value,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       busy,
  output logic                       stack_err
);

  localparam int unsigned DW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LD_A  = 3'd1,
    S_LD_B  = 3'd2,
    S_LD_OP = 3'd3,
    S_EXEC  = 3'd4,
    S_WB    = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    entry_q [DEPTH];
  logic [N-1:0]    entry_d [DEPTH];
  logic [DW-1:0]   depth_q, depth_d;
  logic [N-1:0]    op_q, op_d;
  logic [N-1:0]    hist_a_q, hist_a_d;
  logic [N-1:0]    hist_b_q, hist_b_d;
  logic            hist_valid_q, hist_valid_d;
  logic            err_q, err_d;
  logic [N-1:0]    alu_data_q, alu_data_d;
  logic            load_a_q, load_a_d;
  logic            load_b_q, load_b_d;
  logic            load_op_q, load_op_d;
  logic            update_res_q, update_res_d;
  logic [N-1:0]    top_value_q, top_value_d;
  logic            busy_q, busy_d;

  logic [N-1:0]    sec_val;
  logic [N-1:0]    top_val;

  // Operand views: second-from-top and top of the current stack.
  always_comb begin
    sec_val = '0;
    top_val = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (int'(depth_q) == i + 2) sec_val = entry_q[i];
      if (int'(depth_q) == i + 1) top_val = entry_q[i];
    end
  end

  // Command decode, sequencing and stack update; outputs are precomputed from the next state.
  always_comb begin
    state_d      = state_q;
    entry_d      = entry_q;
    depth_d      = depth_q;
    op_d         = op_q;
    hist_a_d     = hist_a_q;
    hist_b_d     = hist_b_q;
    hist_valid_d = hist_valid_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        if (undo_pulse) begin
          // Undo has priority over a coincident enter.
          if (hist_valid_q) begin
            // Replace the result with the saved operands, B ending on top.
            for (int i = 0; i < int'(DEPTH); i++) begin
              if (int'(depth_q) == i + 1) entry_d[i] = hist_a_q;
              if (int'(depth_q) == i)     entry_d[i] = hist_b_q;
            end
            depth_d      = depth_q + DW'(1);
            hist_valid_d = 1'b0;
            err_d        = 1'b0;
          end else if (depth_q != '0) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
              if (int'(depth_q) == i + 1) entry_d[i] = '0;
            end
            depth_d      = depth_q - DW'(1);
            hist_valid_d = 1'b0;
            err_d        = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else if (enter_pulse) begin
          if (!is_op) begin
            if (depth_q < DW'(DEPTH)) begin
              for (int i = 0; i < int'(DEPTH); i++) begin
                if (int'(depth_q) == i) entry_d[i] = data_in;
              end
              depth_d      = depth_q + DW'(1);
              hist_valid_d = 1'b0;
              err_d        = 1'b0;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            if (depth_q < DW'(2)) begin
              err_d = 1'b1;
            end else begin
              op_d    = data_in;
              err_d   = 1'b0;
              state_d = S_LD_A;
            end
          end
        end
      end
      S_LD_A:  state_d = S_LD_B;
      S_LD_B:  state_d = S_LD_OP;
      S_LD_OP: state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB: begin
        // Collapse the two operands into the ALU result and remember them for undo.
        hist_a_d     = sec_val;
        hist_b_d     = top_val;
        hist_valid_d = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (int'(depth_q) == i + 2) entry_d[i] = alu_result;
          if (int'(depth_q) == i + 1) entry_d[i] = '0;
        end
        depth_d = depth_q - DW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    alu_data_d   = '0;
    load_a_d     = 1'b0;
    load_b_d     = 1'b0;
    load_op_d    = 1'b0;
    update_res_d = 1'b0;
    case (state_d)
      S_LD_A: begin
        alu_data_d = sec_val;
        load_a_d   = 1'b1;
      end
      S_LD_B: begin
        alu_data_d = top_val;
        load_b_d   = 1'b1;
      end
      S_LD_OP: begin
        alu_data_d = op_q;
        load_op_d  = 1'b1;
      end
      S_EXEC:  update_res_d = 1'b1;
      default: ;
    endcase

    busy_d = (state_d != S_IDLE);

    top_value_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (int'(depth_d) == i + 1) top_value_d = entry_d[i];
    end
  end

  // State, stack and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < int'(DEPTH); i++) entry_q[i] <= '0;
      depth_q      <= '0;
      op_q         <= '0;
      hist_a_q     <= '0;
      hist_b_q     <= '0;
      hist_valid_q <= 1'b0;
      err_q        <= 1'b0;
      alu_data_q   <= '0;
      load_a_q     <= 1'b0;
      load_b_q     <= 1'b0;
      load_op_q    <= 1'b0;
      update_res_q <= 1'b0;
      top_value_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      for (int i = 0; i < int'(DEPTH); i++) entry_q[i] <= entry_d[i];
      depth_q      <= depth_d;
      op_q         <= op_d;
      hist_a_q     <= hist_a_d;
      hist_b_q     <= hist_b_d;
      hist_valid_q <= hist_valid_d;
      err_q        <= err_d;
      alu_data_q   <= alu_data_d;
      load_a_q     <= load_a_d;
      load_b_q     <= load_b_d;
      load_op_q    <= load_op_d;
      update_res_q <= update_res_d;
      top_value_q  <= top_value_d;
      busy_q       <= busy_d;
    end
  end

  assign alu_data   = alu_data_q;
  assign load_A     = load_a_q;
  assign load_B     = load_b_q;
  assign load_Op    = load_op_q;
  assign update_res = update_res_q;
  assign top_value  = top_value_q;
  assign depth      = depth_q;
  assign busy       = busy_q;
  assign stack_err  = err_q;

endmodule

// File: tb/tb_rpn_stack_controller.sv
// Scoreboard bench for rpn_stack_controller with a queue-based RPN reference model.
module tb_rpn_stack_controller;

  localparam int unsigned N     = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          enter_pulse, undo_pulse, is_op;
  logic [N-1:0]  data_in;
  logic [N-1:0]  alu_result = '0;
  logic [N-1:0]  alu_data, top_value;
  logic          load_A, load_B, load_Op, update_res, busy, stack_err;
  logic [DW-1:0] depth;

  rpn_stack_controller #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enter_pulse(enter_pulse), .undo_pulse(undo_pulse),
    .is_op(is_op), .data_in(data_in), .alu_result(alu_result), .alu_data(alu_data),
    .load_A(load_A), .load_B(load_B), .load_Op(load_Op), .update_res(update_res),
    .top_value(top_value), .depth(depth), .busy(busy), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural ALU: opcode selects the operation on the registered A/B inputs.
  function automatic logic [N-1:0] alu_f(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [N-1:0] op);
    logic [2:0] sel;
    sel = op[2:0];
    case (sel)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return N'(a * b);
      default: return ~a;
    endcase
  endfunction

  // ALU stand-in driven by the DUT strobes.
  logic [N-1:0] alu_a, alu_b, alu_op;
  always @(posedge clk) begin
    if (load_A)     alu_a <= alu_data;
    if (load_B)     alu_b <= alu_data;
    if (load_Op)    alu_op <= alu_data;
    if (update_res) alu_result <= alu_f(alu_a, alu_b, alu_op);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           kind;
    logic [N-1:0] data;
    int           cyc;
  } exp_t;
  exp_t exq[$];

  // Reference model state.
  logic [N-1:0] ms[$];
  bit           hv;
  logic [N-1:0] ha, hb;
  bit           merr;

  // Monitor: every strobe cycle pops one expected strobe; quiet cycles must drive zero.
  bit   mon_en = 1'b0;
  int   mon_ns, mon_kind;
  exp_t mon_e;
  always @(negedge clk) begin
    if (mon_en) begin
      mon_ns = int'(load_A) + int'(load_B) + int'(load_Op) + int'(update_res);
      chk("strobe_onehot", 32'(mon_ns <= 1), 32'd1);
      if (mon_ns == 1) begin
        mon_kind = load_A ? 0 : load_B ? 1 : load_Op ? 2 : 3;
        if (exq.size() == 0) begin
          chk("unexpected_strobe", 32'(mon_kind), 32'd99);
        end else begin
          mon_e = exq.pop_front();
          chk("strobe_kind", 32'(mon_kind), 32'(mon_e.kind));
          chk("strobe_data", 32'(alu_data), 32'(mon_e.data));
          chk("strobe_cycle", 32'(cyc), 32'(mon_e.cyc));
        end
      end else if (mon_ns == 0) begin
        chk("idle_alu_data", 32'(alu_data), 32'd0);
      end
    end
  end

  function automatic logic [N-1:0] model_top();
    if (ms.size() == 0) return '0;
    return ms[ms.size()-1];
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_depth"}, 32'(depth), 32'(ms.size()));
    chk({tag, "_top"},   32'(top_value), 32'(model_top()));
    chk({tag, "_err"},   32'(stack_err), 32'(merr));
    chk({tag, "_busy"},  32'(busy), 32'd0);
  endtask

  // Drive one command cycle; called and returns at posedge+1.
  task automatic issue(input logic en, input logic un, input logic op, input logic [N-1:0] d);
    enter_pulse = en;
    undo_pulse  = un;
    is_op       = op;
    data_in     = d;
    @(posedge clk); #1;
    enter_pulse = 1'b0;
    undo_pulse  = 1'b0;
    is_op       = 1'($urandom);
    data_in     = N'($urandom);
  endtask

  task automatic model_undo();
    if (hv) begin
      void'(ms.pop_back());
      ms.push_back(ha);
      ms.push_back(hb);
      hv   = 1'b0;
      merr = 1'b0;
    end else if (ms.size() > 0) begin
      void'(ms.pop_back());
      hv   = 1'b0;
      merr = 1'b0;
    end else begin
      merr = 1'b1;
    end
  endtask

  task automatic cmd_push(input logic [N-1:0] v);
    if (ms.size() < int'(DEPTH)) begin
      ms.push_back(v);
      hv   = 1'b0;
      merr = 1'b0;
    end else begin
      merr = 1'b1;
    end
    issue(1'b1, 1'b0, 1'b0, v);
    check_state("push");
  endtask

  task automatic cmd_undo(input bit with_enter);
    model_undo();
    issue(with_enter, 1'b1, 1'($urandom), N'($urandom));
    check_state(with_enter ? "undo_enter" : "undo");
  endtask

  task automatic cmd_op(input logic [N-1:0] opc, input bit inject);
    int c0, n, lat;
    logic [N-1:0] a, b;
    c0 = cyc;
    lat = 0;
    if (ms.size() >= 2) begin
      a = ms[ms.size()-2];
      b = ms[ms.size()-1];
      exq.push_back('{kind: 0, data: a,   cyc: c0 + 1});
      exq.push_back('{kind: 1, data: b,   cyc: c0 + 2});
      exq.push_back('{kind: 2, data: opc, cyc: c0 + 3});
      exq.push_back('{kind: 3, data: '0,  cyc: c0 + 4});
      void'(ms.pop_back());
      void'(ms.pop_back());
      ms.push_back(alu_f(a, b, opc));
      ha = a; hb = b; hv = 1'b1;
      merr = 1'b0;
      lat = 5;
    end else begin
      merr = 1'b1;
    end
    issue(1'b1, 1'b0, 1'b1, opc);
    if (inject && lat != 0) begin
      // Commands landing in LD_B must be ignored.
      @(posedge clk); #1;
      enter_pulse = 1'b1;
      undo_pulse  = 1'b1;
      is_op       = 1'($urandom);
      data_in     = N'($urandom);
      @(posedge clk); #1;
      enter_pulse = 1'b0;
      undo_pulse  = 1'b0;
    end
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("op_latency", 32'(cyc - c0 - 1), 32'(lat));
    check_state("op");
  endtask

  task automatic reset_mid_op(input logic [N-1:0] opc);
    int c0;
    c0 = cyc;
    exq.push_back('{kind: 0, data: ms[ms.size()-2], cyc: c0 + 1});
    exq.push_back('{kind: 1, data: ms[ms.size()-1], cyc: c0 + 2});
    exq.push_back('{kind: 2, data: opc,             cyc: c0 + 3});
    issue(1'b1, 1'b0, 1'b1, opc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    ms.delete();
    hv = 1'b0;
    merr = 1'b0;
    chk("rst_alu_data", 32'(alu_data), 32'd0);
    chk("rst_strobes", 32'({load_A, load_B, load_Op, update_res}), 32'd0);
    check_state("rst");
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    enter_pulse = 1'b0;
    undo_pulse = 1'b0;
    is_op = 1'b0;
    data_in = '0;
    hv = 1'b0;
    merr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    chk("reset_alu_data", 32'(alu_data), 32'd0);
    check_state("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic add: 3 5 + -> 8, then undo restores operands, then plain pop.
    cmd_push(16'h0003);
    cmd_push(16'h0005);
    cmd_op(16'h0000, 1'b0);
    chk("add_result", 32'(top_value), 32'h0008);
    cmd_undo(1'b0);
    chk("undo_restore_top", 32'(top_value), 32'h0005);
    cmd_undo(1'b0);
    chk("undo_pop_top", 32'(top_value), 32'h0003);
    cmd_undo(1'b0);

    // Overflow then recovery.
    for (int i = 1; i <= 4; i++) cmd_push(N'(i));
    cmd_push(16'h0009);
    chk("overflow_err", 32'(stack_err), 32'd1);
    cmd_undo(1'b0);
    chk("overflow_clear", 32'(stack_err), 32'd0);
    repeat (3) cmd_undo(1'b0);

    // Underflow on op and on undo.
    cmd_push(16'h0007);
    cmd_op(16'h0000, 1'b0);
    cmd_undo(1'b0);
    cmd_undo(1'b0);
    chk("underflow_err", 32'(stack_err), 32'd1);

    // Commands during the sequence are ignored; simultaneous enter+undo pops only.
    cmd_push(16'h1234);
    cmd_push(16'h0101);
    cmd_op(16'h0001, 1'b1);
    cmd_push(16'h00ff);
    cmd_undo(1'b1);

    // Reset in the middle of an operation.
    cmd_push(16'h0042);
    reset_mid_op(16'h0004);

    // Randomized command stream.
    for (int k = 0; k < 300; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 40)      cmd_push(N'($urandom));
      else if (r < 65) cmd_op(N'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
      else if (r < 90) cmd_undo(1'b0);
      else             cmd_undo(1'b1);
    end

    repeat (8) @(posedge clk);
    #1;
    chk("exp_queue_empty", 32'(exq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
